// File: rtl/gol_sequencer_if.sv
// rtl/gol_sequencer_if.sv - host and PE-array signal bundle for gol_sequencer
// Purpose: groups the host load/run/dump handshakes, status outputs and the
//          PE-array command/address/data signals.
// Modports:
//   slave  - the sequencer: host starts/beats and array readback in; ready,
//            readout beats, status and array commands out.
//   master - the host/array side (mirror of slave).
interface gol_sequencer_if #(
    parameter int PX_BITS = 3,
    parameter int PY_BITS = 3,
    parameter int GEN_W   = 16,
    parameter int CMD_W   = 2
);
    logic               load_start;
    logic               load_valid;
    logic               load_data;
    logic               load_ready;
    logic               run_start;
    logic [GEN_W-1:0]   run_gens;
    logic               dump_start;
    logic               out_valid;
    logic               out_data;
    logic               out_last;
    logic               out_ready;
    logic               busy;
    logic               done;
    logic [GEN_W-1:0]   gen_count;
    logic               halted;
    logic [CMD_W-1:0]   pe_cmd;
    logic               pe_state_in;
    logic [PX_BITS-1:0] pe_adr_x_i;
    logic [PY_BITS-1:0] pe_adr_y_i;
    logic [PX_BITS-1:0] pe_adr_x_o;
    logic [PY_BITS-1:0] pe_adr_y_o;
    logic               pe_state_out;
    logic               pe_active;

    modport slave (
        input  load_start, load_valid, load_data, run_start, run_gens, dump_start,
               out_ready, pe_state_out, pe_active,
        output load_ready, out_valid, out_data, out_last, busy, done, gen_count,
               halted, pe_cmd, pe_state_in, pe_adr_x_i, pe_adr_y_i, pe_adr_x_o, pe_adr_y_o
    );

    modport master (
        output load_start, load_valid, load_data, run_start, run_gens, dump_start,
               out_ready, pe_state_out, pe_active,
        input  load_ready, out_valid, out_data, out_last, busy, done, gen_count,
               halted, pe_cmd, pe_state_in, pe_adr_x_i, pe_adr_y_i, pe_adr_x_o, pe_adr_y_o
    );
endinterface

// File: rtl/gol_sequencer.sv
// rtl/gol_sequencer.sv - Game-of-Life PE array load/run/dump sequencer
// Purpose: loads a grid in raster order, runs N generations (stopping early
//          when no cell is active) and streams the grid back out. Sole driver
//          of the array's command, write-data and address ports.
// Ports:
//   i_clk     - system clock, rising edge
//   i_reset_n - asynchronous active-low reset
//   bus       - gol_sequencer_if.slave (host handshakes, status, array side)
module gol_sequencer #(
    parameter int N_PX    = 8,
    parameter int N_PY    = 8,
    parameter int PX_BITS = 3,
    parameter int PY_BITS = 3,
    parameter int GEN_W   = 16,
    parameter int CMD_W   = 2
) (
    input logic            i_clk,
    input logic            i_reset_n,
    gol_sequencer_if.slave bus
);
    localparam logic [CMD_W-1:0]   CMD_NOP  = CMD_W'(0);
    localparam logic [CMD_W-1:0]   CMD_LOAD = CMD_W'(1);
    localparam logic [CMD_W-1:0]   CMD_STEP = CMD_W'(2);
    localparam logic [PX_BITS-1:0] X_LAST   = PX_BITS'(N_PX - 1);
    localparam logic [PY_BITS-1:0] Y_LAST   = PY_BITS'(N_PY - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_RUN_STEP, S_RUN_CHK, S_DUMP_ADR, S_DUMP_OUT, S_FIN
    } state_t;

    state_t             r_state;
    logic [PX_BITS-1:0] r_cx;
    logic [PY_BITS-1:0] r_cy;
    logic [GEN_W-1:0]   r_gens;

    logic               w_last_cell;
    logic [PX_BITS-1:0] w_nx;
    logic [PY_BITS-1:0] w_ny;

    // Raster walk: x fastest, wrapping to 0 and bumping y.
    assign w_last_cell = (r_cx == X_LAST) && (r_cy == Y_LAST);
    assign w_nx        = (r_cx == X_LAST) ? '0 : r_cx + PX_BITS'(1);
    assign w_ny        = (r_cx == X_LAST) ? r_cy + PY_BITS'(1) : r_cy;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state         <= S_IDLE;
            r_cx            <= '0;
            r_cy            <= '0;
            r_gens          <= '0;
            bus.load_ready  <= 1'b0;
            bus.out_valid   <= 1'b0;
            bus.out_data    <= 1'b0;
            bus.out_last    <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.gen_count   <= '0;
            bus.halted      <= 1'b0;
            bus.pe_cmd      <= CMD_NOP;
            bus.pe_state_in <= 1'b0;
            bus.pe_adr_x_i  <= '0;
            bus.pe_adr_y_i  <= '0;
            bus.pe_adr_x_o  <= '0;
            bus.pe_adr_y_o  <= '0;
        end else begin
            bus.done   <= 1'b0;
            bus.pe_cmd <= CMD_NOP;
            case (r_state)
                S_IDLE: begin
                    if (bus.load_start) begin
                        r_state        <= S_LOAD;
                        bus.busy       <= 1'b1;
                        bus.load_ready <= 1'b1;
                        r_cx           <= '0;
                        r_cy           <= '0;
                    end else if (bus.run_start) begin
                        r_state       <= S_RUN_STEP;
                        bus.busy      <= 1'b1;
                        r_gens        <= bus.run_gens;
                        bus.gen_count <= '0;
                        bus.halted    <= 1'b0;
                        // Zero generations still passes through RUN_STEP, but with NOP.
                        if (bus.run_gens != '0)
                            bus.pe_cmd <= CMD_STEP;
                    end else if (bus.dump_start) begin
                        r_state        <= S_DUMP_ADR;
                        bus.busy       <= 1'b1;
                        r_cx           <= '0;
                        r_cy           <= '0;
                        bus.pe_adr_x_o <= '0;
                        bus.pe_adr_y_o <= '0;
                    end
                end
                S_LOAD: begin
                    // load_ready low here means the final LOAD is on the array this cycle.
                    if (!bus.load_ready) begin
                        r_state  <= S_FIN;
                        bus.done <= 1'b1;
                    end else if (bus.load_valid) begin
                        bus.pe_cmd      <= CMD_LOAD;
                        bus.pe_adr_x_i  <= r_cx;
                        bus.pe_adr_y_i  <= r_cy;
                        bus.pe_state_in <= bus.load_data;
                        if (w_last_cell) begin
                            bus.load_ready <= 1'b0;
                        end else begin
                            r_cx <= w_nx;
                            r_cy <= w_ny;
                        end
                    end
                end
                S_RUN_STEP: begin
                    if (r_gens == '0) begin
                        r_state  <= S_FIN;
                        bus.done <= 1'b1;
                    end else begin
                        r_state       <= S_RUN_CHK;
                        bus.gen_count <= bus.gen_count + GEN_W'(1);
                    end
                end
                S_RUN_CHK: begin
                    if (!bus.pe_active) begin
                        r_state    <= S_FIN;
                        bus.halted <= 1'b1;
                        bus.done   <= 1'b1;
                    end else if (bus.gen_count == r_gens) begin
                        r_state  <= S_FIN;
                        bus.done <= 1'b1;
                    end else begin
                        r_state    <= S_RUN_STEP;
                        bus.pe_cmd <= CMD_STEP;
                    end
                end
                S_DUMP_ADR: begin
                    // Read address has been stable a full cycle; array output is valid.
                    r_state       <= S_DUMP_OUT;
                    bus.out_valid <= 1'b1;
                    bus.out_data  <= bus.pe_state_out;
                    bus.out_last  <= w_last_cell;
                end
                S_DUMP_OUT: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.out_last  <= 1'b0;
                        if (w_last_cell) begin
                            r_state  <= S_FIN;
                            bus.done <= 1'b1;
                        end else begin
                            r_state        <= S_DUMP_ADR;
                            r_cx           <= w_nx;
                            r_cy           <= w_ny;
                            bus.pe_adr_x_o <= w_nx;
                            bus.pe_adr_y_o <= w_ny;
                        end
                    end
                end
                S_FIN: begin
                    r_state  <= S_IDLE;
                    bus.busy <= 1'b0;
                end
                default: begin
                    r_state  <= S_IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_gol_sequencer.sv
// tb/tb_gol_sequencer.sv - scoreboard bench for gol_sequencer with an 8x8 array model
module tb_gol_sequencer;
    localparam logic [63:0] GLIDER  = (64'd1 << 1) | (64'd1 << 10) | (64'd1 << 16) |
                                      (64'd1 << 17) | (64'd1 << 18);
    localparam logic [63:0] BLINKER = (64'd1 << 19) | (64'd1 << 27) | (64'd1 << 35);
    localparam logic [63:0] SINGLE  = (64'd1 << 27);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gol_sequencer_if bus ();

    gol_sequencer dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    // Array model: bounded (non-wrapping) 8x8 life grid, index = y*8+x.
    logic [63:0] grid = '0;

    function automatic logic [63:0] life_step(input logic [63:0] g);
        logic [63:0] n;
        int c, yy, xx;
        n = '0;
        for (int y = 0; y < 8; y++) begin
            for (int x = 0; x < 8; x++) begin
                c = 0;
                for (int dy = -1; dy <= 1; dy++) begin
                    for (int dx = -1; dx <= 1; dx++) begin
                        yy = y + dy;
                        xx = x + dx;
                        if ((dy != 0 || dx != 0) && yy >= 0 && yy < 8 && xx >= 0 && xx < 8)
                            c += int'(g[yy*8+xx]);
                    end
                end
                n[y*8+x] = (c == 3) || (g[y*8+x] && c == 2);
            end
        end
        return n;
    endfunction

    assign bus.pe_state_out = grid[{bus.pe_adr_y_o, bus.pe_adr_x_o}];
    assign bus.pe_active    = |grid;

    always @(posedge clk) begin
        if (bus.pe_cmd == 2'd1)
            grid[{bus.pe_adr_y_i, bus.pe_adr_x_i}] <= bus.pe_state_in;
        else if (bus.pe_cmd == 2'd2)
            grid <= life_step(grid);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboards: expected LOAD commands {index, data} and readout beats {last, data}.
    logic [6:0] lq[$];
    logic [1:0] dq[$];
    int         step_cyc[$];
    int         n_load_cmd = 0;
    int         n_step = 0;
    int         n_done = 0;
    int         n_beat = 0;
    logic [6:0] e_ld;
    logic [1:0] e_dp;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.pe_cmd == 2'd1) begin
                n_load_cmd++;
                if (lq.size() == 0) begin
                    chk("load_extra", 64'd1, 64'd0);
                end else begin
                    e_ld = lq.pop_front();
                    chk("load_adr", 64'({bus.pe_adr_y_i, bus.pe_adr_x_i}), 64'(e_ld[6:1]));
                    chk("load_data", 64'(bus.pe_state_in), 64'(e_ld[0]));
                end
            end
            if (bus.pe_cmd == 2'd2) begin
                n_step++;
                step_cyc.push_back(cyc);
            end
            if (bus.done) n_done++;
            if (bus.out_valid && bus.out_ready) begin
                n_beat++;
                if (dq.size() == 0) begin
                    chk("dump_extra", 64'd1, 64'd0);
                end else begin
                    e_dp = dq.pop_front();
                    chk("dump_beat", 64'({bus.out_last, bus.out_data}), 64'(e_dp));
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int budget, output int dcyc);
        int t;
        t = 0;
        dcyc = -1;
        while (t < budget && dcyc < 0) begin
            @(negedge clk);
            if (bus.done) dcyc = cyc;
            t++;
        end
        if (dcyc < 0) chk("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_load(input logic [63:0] pat, input bit toggle, input bit also_run);
        logic [63:0] p;
        int d;
        p = pat;
        tick(1);
        bus.load_start = 1'b1;
        bus.run_start  = also_run;
        tick(1);
        bus.load_start = 1'b0;
        bus.run_start  = 1'b0;
        chk("load_ready_rise", 64'(bus.load_ready), 64'd1);
        for (int i = 0; i < 64; i++) begin
            bit acc;
            int t;
            acc = 1'b0;
            t = 0;
            bus.load_valid = 1'b1;
            bus.load_data  = p[i];
            lq.push_back({6'(i), p[i]});
            while (!acc && t < 50) begin
                @(negedge clk);
                acc = bus.load_ready;
                @(posedge clk);
                #1;
                t++;
            end
            if (!acc) chk("load_timeout", 64'd0, 64'd1);
            bus.load_valid = 1'b0;
            if (toggle) tick(1);
        end
        wait_done(20, d);
        chk("load_ready_drop", 64'(bus.load_ready), 64'd0);
    endtask

    task automatic do_run(input int gens, input bit poke, output int c0, output int dcyc);
        tick(1);
        bus.run_start = 1'b1;
        bus.run_gens  = 16'(gens);
        c0 = cyc;
        step_cyc.delete();
        tick(1);
        bus.run_start = 1'b0;
        if (poke) begin
            bus.load_start = 1'b1;
            tick(1);
            bus.load_start = 1'b0;
        end
        wait_done(2 * gens + 10, dcyc);
    endtask

    task automatic do_dump(input logic [63:0] pat, input bit stall);
        logic [63:0] p;
        int d;
        int b0;
        p = pat;
        b0 = n_beat;
        for (int i = 0; i < 64; i++) dq.push_back({(i == 63), p[i]});
        tick(1);
        bus.dump_start = 1'b1;
        bus.out_ready  = !stall;
        tick(1);
        bus.dump_start = 1'b0;
        if (!stall) begin
            wait_done(300, d);
            bus.out_ready = 1'b0;
        end else begin
            for (int i = 0; i < 64; i++) begin
                int t;
                t = 0;
                @(negedge clk);
                while (!bus.out_valid && t < 10) begin
                    @(negedge clk);
                    t++;
                end
                for (int k = 0; k < 5; k++) begin
                    chk("stall_beat", 64'({bus.out_valid, bus.out_data}), 64'({1'b1, p[i]}));
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
                @(posedge clk);
                #1;
                bus.out_ready = 1'b0;
            end
            wait_done(10, d);
        end
        tick(2);
        chk("dump_beats", 64'(n_beat - b0), 64'd64);
        chk("dump_q_empty", 64'(dq.size()), 64'd0);
    endtask

    int c0, dcyc, ld0, st0, dn0;

    initial begin
        bus.load_start = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_data  = 1'b0;
        bus.run_start  = 1'b0;
        bus.run_gens   = '0;
        bus.dump_start = 1'b0;
        bus.out_ready  = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", 64'({bus.busy, bus.done, bus.load_ready, bus.out_valid, bus.pe_cmd,
                              bus.gen_count, bus.halted}), 64'd0);
        rst_n = 1'b1;
        tick(2);

        // T2: glider load with toggling valid; simultaneous run_start must lose to load_start.
        ld0 = n_load_cmd; st0 = n_step; dn0 = n_done;
        do_load(GLIDER, 1'b1, 1'b1);
        tick(2);
        chk("t2_loads", 64'(n_load_cmd - ld0), 64'd64);
        chk("t2_steps", 64'(n_step - st0), 64'd0);
        chk("t2_done", 64'(n_done - dn0), 64'd1);
        chk("t2_lq_empty", 64'(lq.size()), 64'd0);
        chk("t2_idle", 64'(bus.busy), 64'd0);

        // T6: stalled dump of the glider.
        do_dump(GLIDER, 1'b1);

        // T3: blinker, 4 generations, with an ignored load_start while busy.
        do_load(BLINKER, 1'b0, 1'b0);
        tick(2);
        ld0 = n_load_cmd; st0 = n_step;
        do_run(4, 1'b1, c0, dcyc);
        tick(2);
        chk("t3_steps", 64'(n_step - st0), 64'd4);
        for (int k = 0; k < 4 && k < step_cyc.size(); k++)
            chk("t3_step_cyc", 64'(step_cyc[k] - c0), 64'(1 + 2 * k));
        chk("t3_done_cyc", 64'(dcyc - c0), 64'd9);
        chk("t3_gen_count", 64'(bus.gen_count), 64'd4);
        chk("t3_halted", 64'(bus.halted), 64'd0);
        chk("t3_no_load", 64'(n_load_cmd - ld0), 64'd0);
        do_dump(BLINKER, 1'b0);

        // T4: lone cell dies after one generation.
        do_load(SINGLE, 1'b0, 1'b0);
        tick(2);
        st0 = n_step; dn0 = n_done;
        do_run(10, 1'b0, c0, dcyc);
        tick(2);
        chk("t4_steps", 64'(n_step - st0), 64'd1);
        chk("t4_gen_count", 64'(bus.gen_count), 64'd1);
        chk("t4_halted", 64'(bus.halted), 64'd1);
        chk("t4_done", 64'(n_done - dn0), 64'd1);

        // T5: zero generations.
        st0 = n_step;
        do_run(0, 1'b0, c0, dcyc);
        tick(2);
        chk("t5_steps", 64'(n_step - st0), 64'd0);
        chk("t5_done_cyc", 64'(dcyc - c0), 64'd2);
        chk("t5_gen_count", 64'(bus.gen_count), 64'd0);
        chk("t5_halted", 64'(bus.halted), 64'd0);

        // T1: asynchronous reset in the middle of a run.
        do_load(BLINKER, 1'b0, 1'b0);
        tick(2);
        bus.run_start = 1'b1;
        bus.run_gens  = 16'd10;
        tick(1);
        bus.run_start = 1'b0;
        tick(4);
        chk("t1_busy_before", 64'(bus.busy), 64'd1);
        #2;
        dn0 = n_done;
        rst_n = 1'b0;
        #1;
        chk("t1_rst_outs", 64'({bus.busy, bus.done, bus.load_ready, bus.out_valid, bus.out_data,
                                bus.out_last, bus.halted, bus.pe_state_in, bus.pe_cmd,
                                bus.gen_count, bus.pe_adr_x_i, bus.pe_adr_y_i,
                                bus.pe_adr_x_o, bus.pe_adr_y_o}), 64'd0);
        tick(2);
        rst_n = 1'b1;
        tick(6);
        chk("t1_busy_after", 64'(bus.busy), 64'd0);
        chk("t1_no_done", 64'(n_done - dn0), 64'd0);
        chk("t1_cmd_nop", 64'(bus.pe_cmd), 64'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
